vline_buffer: RTL and testbench
===============================

VLINE_BUFFER -- requirements
Module: vline_buffer

Interface
REQ-001 Parameter AWIDTH, default 8, pixel address width.
REQ-002 Parameter BPP, default 6, bits per pixel.
REQ-003 Parameter PSIZE, default 160, pixels per bank; SHALL satisfy 2 <= PSIZE <= 2**AWIDTH.
REQ-004 Clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Blank  input  1  blanking; forces black output.
REQ-007 ReadAddress  input  AWIDTH  scanout pixel index into front bank.
REQ-008 LineEnd  input  1  one-cycle pulse at end of line; bank swap request.
REQ-009 DataIn  input  BPP  fill pixel from memory fetcher.
REQ-010 DataValid  input  1  DataIn valid.
REQ-011 DataReady  output  1  buffer accepts fill data this cycle.
REQ-012 VideoOut  output  BPP  registered pixel output.
REQ-013 Underrun  output  1  one-cycle pulse; swap requested while back bank not full.

Function
REQ-014 Storage SHALL be two banks of PSIZE x BPP; FrontSel selects the front (scanout) bank, the other is the back (fill) bank.
REQ-015 Fill FSM SHALL have states FILL and FULL; DataReady = 1 in FILL, 0 in FULL and while Reset is high.
REQ-016 Transfer occurs when DataValid && DataReady; the buffer SHALL write DataIn to back[WrPtr] and increment WrPtr.
REQ-017 On a transfer with WrPtr == PSIZE-1 the FSM SHALL go FILL -> FULL and WrPtr SHALL wrap to 0.
REQ-018 LineEnd in FULL SHALL toggle FrontSel and return FSM to FILL; DataReady = 1 on the following cycle.
REQ-019 LineEnd in FILL SHALL not swap; Underrun pulses high for exactly the next cycle; fill continues from the current WrPtr.
REQ-020 LineEnd coinciding with the final transfer (WrPtr == PSIZE-1) SHALL count as full: the word is written, the swap occurs, no Underrun, FSM ends in FILL with WrPtr = 0.
REQ-021 VideoOut latency SHALL be 1 cycle: Blank -> 0; else ReadAddress >= PSIZE -> 0; else front[ReadAddress].
REQ-022 A read in the same cycle as a swap SHALL use the pre-swap FrontSel.
REQ-023 DataIn with DataValid while DataReady = 0 SHALL be ignored (no write, no pointer change).

Reset
REQ-024 Reset SHALL set VideoOut = 0, Underrun = 0, FrontSel = 0, WrPtr = 0, FSM = FILL; bank contents are not cleared.
REQ-025 Reset mid-fill SHALL discard the partial line; Reset dominates LineEnd and transfers in the same cycle.

Configuration
REQ-026 Macro VLINE_BUFFER_UNDERRUN_COUNT_EN: when defined, adds output UnderrunCount (8 bits), incremented on each Underrun pulse, saturating at 255, cleared by Reset.
REQ-027 Without VLINE_BUFFER_UNDERRUN_COUNT_EN the port and counter SHALL not exist; all other behaviour is identical.

Verification
REQ-028 PSIZE=4: reset, stream 10,11,12,13 with DataValid held -> DataReady drops after 4th transfer; LineEnd -> ReadAddress 0..3 gives 10..13 one cycle later.
REQ-029 LineEnd after only 2 of 4 transfers -> Underrun pulses 1 cycle, front bank unchanged, next 2 transfers complete fill, next LineEnd swaps.
REQ-030 LineEnd in the same cycle as the 4th transfer (value 23) -> swap, no Underrun, ReadAddress 3 returns 23.
REQ-031 Blank = 1 with valid ReadAddress -> VideoOut = 0; ReadAddress = 5 with PSIZE=4, Blank = 0 -> VideoOut = 0.
REQ-032 Reset after 2 transfers -> DataReady = 0 during Reset, then WrPtr restarts at 0; 4 fresh transfers required before swap.
REQ-033 With VLINE_BUFFER_UNDERRUN_COUNT_EN: 300 underrunning LineEnd pulses -> UnderrunCount = 255; Reset -> 0.

Source files
------------

// File: rtl/vline_buffer.sv
// vline_buffer: ping-pong scanline buffer, fetcher fills the back bank while the front bank is scanned out.
// Optional macro VLINE_BUFFER_UNDERRUN_COUNT_EN adds a saturating UnderrunCount output.
module vline_buffer #(
  parameter int AWIDTH = 8,
  parameter int BPP    = 6,
  parameter int PSIZE  = 160
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Blank,
  input  logic [AWIDTH-1:0] ReadAddress,
  input  logic              LineEnd,
  input  logic [BPP-1:0]    DataIn,
  input  logic              DataValid,
  output logic              DataReady,
  output logic [BPP-1:0]    VideoOut,
`ifdef VLINE_BUFFER_UNDERRUN_COUNT_EN
  output logic [7:0]        UnderrunCount,
`endif
  output logic              Underrun
);
  typedef enum logic {FILL, FULL} state_t;
  state_t state, state_nx;
  logic front_sel;
  logic [AWIDTH-1:0] wr_ptr;
  logic [BPP-1:0] mem [2][PSIZE];
  logic xfer, last, swap, in_range;
  always_comb begin
    xfer = DataValid && DataReady;
    last = xfer && wr_ptr == AWIDTH'(PSIZE - 1);
    swap = LineEnd && (state == FULL || last);
    in_range = {1'b0, ReadAddress} < (AWIDTH + 1)'(PSIZE);
  end
  always_ff @(posedge Clk)
    state <= Reset ? FILL : state_nx;
  // a final transfer coinciding with LineEnd swaps immediately, so FULL is skipped
  always_comb
    state_nx = (state == FULL) ? (LineEnd ? FILL : FULL) : ((last && !LineEnd) ? FULL : FILL);
  always_comb
    DataReady = state == FILL && !Reset;
  always_ff @(posedge Clk)
    if (xfer) mem[!front_sel][wr_ptr] <= DataIn;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      front_sel <= 1'b0;
      wr_ptr    <= '0;
      Underrun  <= 1'b0;
      VideoOut  <= '0;
    end else begin
      if (xfer) wr_ptr <= last ? '0 : wr_ptr + 1'b1;
      if (swap) front_sel <= !front_sel;
      Underrun <= LineEnd && !swap;
      VideoOut <= (Blank || !in_range) ? '0 : mem[front_sel][ReadAddress];
    end
  end
`ifdef VLINE_BUFFER_UNDERRUN_COUNT_EN
  always_ff @(posedge Clk)
    if (Reset) UnderrunCount <= '0;
    else if (Underrun && UnderrunCount != 8'hff) UnderrunCount <= UnderrunCount + 8'd1;
`endif
endmodule

// File: tb/tb_vline_buffer.sv
// tb_vline_buffer: directed scoreboard bench for vline_buffer with a 4-pixel line.
module tb_vline_buffer;
  localparam int AW = 8, BP = 6, PS = 4;
  logic Clk = 0, Reset = 1, Blank = 0, LineEnd = 0, DataValid = 0;
  logic [AW-1:0] ReadAddress = '0;
  logic [BP-1:0] DataIn = '0;
  logic DataReady, Underrun;
  logic [BP-1:0] VideoOut;
`ifdef VLINE_BUFFER_UNDERRUN_COUNT_EN
  logic [7:0] UnderrunCount;
`endif
  logic rd_v = 0, rd_v_d = 0;
  logic [BP-1:0] sb [$];
  int n_cmp = 0, n_bad = 0;

  vline_buffer #(.AWIDTH(AW), .BPP(BP), .PSIZE(PS)) dut (
    .Clk(Clk), .Reset(Reset), .Blank(Blank), .ReadAddress(ReadAddress),
    .LineEnd(LineEnd), .DataIn(DataIn), .DataValid(DataValid),
    .DataReady(DataReady), .VideoOut(VideoOut),
`ifdef VLINE_BUFFER_UNDERRUN_COUNT_EN
    .UnderrunCount(UnderrunCount),
`endif
    .Underrun(Underrun));

  always #5 Clk = ~Clk;

  always @(posedge Clk) rd_v_d <= rd_v;

  // monitor: a read issued in one cycle is presented on VideoOut after that edge
  always @(negedge Clk)
    if (rd_v_d) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL pixel: got %0d, scoreboard empty", VideoOut);
      end else begin
        automatic logic [BP-1:0] e = sb.pop_front();
        if (VideoOut !== e) begin
          n_bad++;
          $display("FAIL pixel: got %0d, expected %0d", VideoOut, e);
        end
      end
    end

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc(input logic v, input int d, input logic le, input int ra, input logic rd, input int e);
    DataValid = v;
    DataIn = BP'(d);
    LineEnd = le;
    ReadAddress = AW'(ra);
    rd_v = rd;
    if (rd) sb.push_back(BP'(e));
    @(posedge Clk);
    #1;
  endtask

  task automatic fill(input int d);
    cyc(1, d, 0, 0, 0, 0);
  endtask

  task automatic rd(input int a, input int e);
    cyc(0, 0, 0, a, 1, e);
  endtask

  initial begin
    #1;
    chk("ready_in_reset", DataReady, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("reset_video", VideoOut, 0);
    chk("reset_underrun", Underrun, 0);
    Reset = 0;
    #1;
    chk("ready_after_reset", DataReady, 1);
    // full line, then a transfer attempt while FULL that must be ignored
    fill(10); fill(11); fill(12);
    chk("ready_before_last", DataReady, 1);
    fill(13);
    chk("ready_full", DataReady, 0);
    fill(63);
    cyc(0, 0, 1, 0, 0, 0);
    chk("ready_after_swap", DataReady, 1);
    chk("no_underrun_swap", Underrun, 0);
    rd(0, 10); rd(1, 11); rd(2, 12); rd(3, 13);
    // early LineEnd: underrun, no swap, fill resumes
    fill(20); fill(21);
    cyc(0, 0, 1, 0, 0, 0);
    chk("underrun_pulse", Underrun, 1);
    rd(0, 10);
    chk("underrun_one_cycle", Underrun, 0);
    chk("ready_after_underrun", DataReady, 1);
    fill(22); fill(23);
    chk("ready_full2", DataReady, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("no_underrun2", Underrun, 0);
    rd(0, 20); rd(1, 21); rd(2, 22); rd(3, 23);
    // LineEnd with the final transfer, plus a read on the swap cycle
    fill(30); fill(31); fill(32);
    cyc(1, 23, 1, 0, 1, 20);
    chk("coincident_no_underrun", Underrun, 0);
    chk("coincident_ready", DataReady, 1);
    rd(3, 23); rd(0, 30);
    // blanking and out-of-range addresses
    Blank = 1;
    rd(1, 0);
    Blank = 0;
    rd(5, 0); rd(4, 0); rd(2, 32);
    // reset mid-fill dominates LineEnd and a pending transfer
    fill(40); fill(41);
    Reset = 1;
    DataValid = 1; DataIn = 42; LineEnd = 1;
    #1;
    chk("ready_during_reset", DataReady, 0);
    @(posedge Clk);
    #1;
    Reset = 0;
    cyc(0, 0, 0, 0, 0, 0);
    chk("reset_no_underrun", Underrun, 0);
    rd(0, 40); rd(2, 22);
    fill(50); fill(51); fill(52);
    chk("refill_needs_four", DataReady, 1);
    fill(53);
    chk("refill_full", DataReady, 0);
    cyc(0, 0, 1, 0, 0, 0);
    rd(0, 50); rd(1, 51); rd(2, 52); rd(3, 53);
`ifdef VLINE_BUFFER_UNDERRUN_COUNT_EN
    Reset = 1;
    cyc(0, 0, 0, 0, 0, 0);
    Reset = 0;
    for (int i = 0; i < 300; i++) cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("underrun_count_sat", UnderrunCount, 255);
    Reset = 1;
    cyc(0, 0, 0, 0, 0, 0);
    Reset = 0;
    chk("underrun_count_reset", UnderrunCount, 0);
`endif
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
